// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding.
package serial_frame_rx_pkg;
  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DATA   = 2'd1;
  localparam state_t PARITY = 2'd2;
  localparam state_t STOP   = 2'd3;
endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial line in, recovered word and status strobes out.
interface serial_frame_rx_if #(parameter int DATA_W = 8);
  logic              bit_en;
  logic              rx;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              par_err;
  logic              frm_err;
  logic              busy;

  modport master (output bit_en, rx,
                  input  data_out, valid, par_err, frm_err, busy);
  modport slave  (input  bit_en, rx,
                  output data_out, valid, par_err, frm_err, busy);
endinterface

// File: rtl/serial_frame_rx_sipo_shift.sv
// Serial-in/parallel-out register; new bits enter at the MSB so an LSB-first
// stream lands in natural bit order after W shifts.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  generate
    if (W == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    r_q <= '0;
        else if (i_en) r_q <= i_bit;
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    r_q <= '0;
        else if (i_en) r_q <= {i_bit, r_q[W-1:1]};
    end
  endgenerate

  assign o_q = r_q;
endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start, DATA_W bits LSB first, optional even parity,
// stop. Registered word output with one-cycle valid / error strobes.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  serial_frame_rx_if.slave  bus
);
  localparam int CW = $clog2(DATA_W + 1);

  state_t            r_state, w_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_par_bit;
  logic [DATA_W-1:0] w_shreg;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid, r_perr, r_ferr, r_busy;
  logic              w_shift, w_last, w_par_ok;
  logic              w_good, w_perr, w_ferr;

  assign w_last   = (r_cnt == CW'(DATA_W - 1));
  assign w_par_ok = (PARITY_EN == 0) || ((^w_shreg) == r_par_bit);

  sipo_shift #(.W(DATA_W)) u_shift (
    .clk   (clk),
    .rst_n (reset_n),
    .i_en  (w_shift),
    .i_bit (bus.rx),
    .o_q   (w_shreg)
  );

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nxt;

  always_comb begin
    w_nxt = r_state;
    if (bus.bit_en) begin
      case (r_state)
        IDLE:    if (!bus.rx) w_nxt = DATA;
        DATA:    if (w_last)  w_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  w_nxt = STOP;
        default: w_nxt = IDLE;  // stop sampled as 0 is not reused as a start bit
      endcase
    end
  end

  always_comb begin
    w_shift = 1'b0;
    w_good  = 1'b0;
    w_perr  = 1'b0;
    w_ferr  = 1'b0;
    if (bus.bit_en) begin
      case (r_state)
        DATA: w_shift = 1'b1;
        STOP: begin
          w_good = bus.rx &&  w_par_ok;
          w_perr = bus.rx && !w_par_ok;
          w_ferr = !bus.rx;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt     <= '0;
      r_par_bit <= 1'b0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // strobes last one clk regardless of bit_en spacing
      r_valid <= w_good;
      r_perr  <= w_perr;
      r_ferr  <= w_ferr;
      r_busy  <= (w_nxt != IDLE);
      if (w_good) r_dout <= w_shreg;
      if (bus.bit_en) begin
        if (r_state == IDLE)        r_cnt     <= '0;
        else if (r_state == DATA)   r_cnt     <= r_cnt + CW'(1);
        if (r_state == PARITY)      r_par_bit <= bus.rx;
      end
    end

  assign bus.data_out = r_dout;
  assign bus.valid    = r_valid;
  assign bus.par_err  = r_perr;
  assign bus.frm_err  = r_ferr;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frame table plus reset corner sequences,
// strobes checked against a queue of expected outcomes.
module tb_serial_frame_rx;
  localparam int K_VLD = 0, K_PAR = 1, K_FRM = 2;

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    bit         idle_after;
    int         kind;
    logic [7:0] dout;
  } vec_t;

  typedef struct {
    int         kind;
    logic [7:0] dout;
  } exp_t;

  logic clk, reset_n;
  serial_frame_rx_if #(.DATA_W(8)) sif ();

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif.slave)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  vec_t tbl[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sif.bit_en = 1'b1;
    sif.rx     = b;
    tick();
    sif.bit_en = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stp, input bit idle);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ bad_par);
    send_bit(stp);
    if (idle) send_bit(1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
  endtask

  // strobe monitor
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        prev = 1'b0;
      end else begin
        int   ns, kind;
        exp_t e;
        ns = int'(sif.valid) + int'(sif.par_err) + int'(sif.frm_err);
        if (ns != 0) begin
          chk("onehot", ns, 1);
          chk("one_clk", prev, 0);
          kind = sif.valid ? K_VLD : (sif.par_err ? K_PAR : K_FRM);
          if (q.size() == 0) begin
            chk("unexpected_strobe", kind, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("kind", kind, e.kind);
            chk("data_out", sif.data_out, e.dout);
          end
        end
        prev = (ns != 0);
      end
    end
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, K_VLD, 8'hA5};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 1'b1, K_PAR, 8'hA5};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, K_FRM, 8'hA5};
    tbl[3] = '{8'h81, 1'b0, 1'b1, 1'b1, K_VLD, 8'h81};
    tbl[4] = '{8'h55, 1'b0, 1'b1, 1'b0, K_VLD, 8'h55};
    tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, K_VLD, 8'hFF};

    reset_n    = 1'b1;
    sif.bit_en = 1'b0;
    sif.rx     = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_data_out", sif.data_out, 0);
    chk("rst_valid",    sif.valid,    0);
    chk("rst_par_err",  sif.par_err,  0);
    chk("rst_frm_err",  sif.frm_err,  0);
    chk("rst_busy",     sif.busy,     0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    send_bit(1'b1);

    for (int v = 0; v < 6; v++) begin
      q.push_back('{tbl[v].kind, tbl[v].dout});
      send_frame(tbl[v].data, tbl[v].bad_par, tbl[v].stop, tbl[v].idle_after);
      if (tbl[v].idle_after) begin
        wait_drain();
        chk("idle_busy", sif.busy, 0);
      end
    end

    // reset mid-frame, 4 data bits of 0xC3 in
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
    chk("mid_busy", sif.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",  sif.busy,     0);
    chk("mid_rst_dout",  sif.data_out, 0);
    chk("mid_rst_valid", sif.valid,    0);
    sif.rx = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("post_rst_busy", sif.busy, 0);
    chk("post_rst_noq",  q.size(), 0);

    q.push_back('{K_VLD, 8'h12});
    send_frame(8'h12, 1'b0, 1'b1, 1'b1);
    wait_drain();
    chk("final_dout", sif.data_out, 8'h12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
